// File: rtl/psum_collector_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psum_collector_if : PE-array psum capture and buffer drain handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface psum_collector_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4
);
    logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum;
    logic [NUM_KERNEL-1:0]           i_psum_val;
    logic [BIT_WIDTH*NUM_KERNEL-1:0] o_data;
    logic                            o_data_val;
    logic                            i_data_rdy;
    logic                            o_stall;

    modport slave (
        input  i_psum, i_psum_val, i_data_rdy,
        output o_data, o_data_val, o_stall
    );

    modport master (
        output i_psum, i_psum_val, i_data_rdy,
        input  o_data, o_data_val, o_stall
    );
endinterface
`default_nettype wire

// File: rtl/psum_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psum_collector : captures complete PE-array psum words into a FIFO, drains
//                  them downstream, stalls upstream near full, keeps stats.
// Revision: 1.0
// ---------------------------------------------------------------------------
module psum_collector #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_WIDTH  = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_clr,
    psum_collector_if.slave           bus,
    output logic [LVL_WIDTH-1:0]      o_level,
    output logic [REG_WIDTH-1:0]      o_word_cnt,
    output logic [REG_WIDTH-1:0]      err_psum_val
);
    localparam int WORD_W = BIT_WIDTH * NUM_KERNEL;
    localparam int PTR_W  = LVL_WIDTH - 1;
    localparam logic [LVL_WIDTH-1:0] C_FULL_LVL  = LVL_WIDTH'(FIFO_DEPTH);
    localparam logic [LVL_WIDTH-1:0] C_STALL_LVL = LVL_WIDTH'(FIFO_DEPTH - 2);

    logic [WORD_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_WIDTH-1:0] r_level;
    logic [REG_WIDTH-1:0] r_word_cnt;
    logic [15:0]          r_drop_cnt;
    logic                 r_err_part;
    logic                 r_err_ovf;

    logic w_complete;
    logic w_partial;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf;

    assign w_complete = &bus.i_psum_val;
    assign w_partial  = (|bus.i_psum_val) & ~w_complete;
    assign w_full     = (r_level == C_FULL_LVL);
    assign w_pop      = bus.o_data_val & bus.i_data_rdy;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign w_push     = w_complete & (~w_full | w_pop);
    assign w_ovf      = w_complete & ~w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_psum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_WIDTH'(1);
                2'b01:   r_level <= r_level - LVL_WIDTH'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
            r_drop_cnt <= '0;
            r_err_part <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else if (i_clr) begin
            r_word_cnt <= '0;
            r_drop_cnt <= '0;
            r_err_part <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            if (w_push)    r_word_cnt <= r_word_cnt + REG_WIDTH'(1);
            if (w_partial) r_err_part <= 1'b1;
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign bus.o_data     = r_mem[r_rd_ptr];
    assign bus.o_data_val = (r_level != '0);
    assign bus.o_stall    = (r_level >= C_STALL_LVL);
    assign o_level        = r_level;
    assign o_word_cnt     = r_word_cnt;
    assign err_psum_val   = {r_drop_cnt, {(REG_WIDTH-18){1'b0}}, r_err_ovf, r_err_part};
endmodule
`default_nettype wire

// File: tb/tb_psum_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_psum_collector : directed self-checking bench for psum_collector
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_psum_collector;
    logic        clk;
    logic        rst;
    logic        i_clr;
    logic [3:0]  o_level;
    logic [31:0] o_word_cnt;
    logic [31:0] err_psum_val;

    int n_checks = 0;
    int n_errors = 0;

    psum_collector_if #(.BIT_WIDTH(8), .NUM_KERNEL(4)) bus ();

    psum_collector #(
        .BIT_WIDTH (8),
        .NUM_KERNEL(4),
        .REG_WIDTH (32),
        .FIFO_DEPTH(8),
        .LVL_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (i_clr),
        .bus         (bus),
        .o_level     (o_level),
        .o_word_cnt  (o_word_cnt),
        .err_psum_val(err_psum_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bus.i_psum     = w;
        bus.i_psum_val = 4'hF;
        tick();
        bus.i_psum_val = 4'h0;
    endtask

    initial begin
        rst            = 1'b0;
        i_clr          = 1'b0;
        bus.i_psum     = '0;
        bus.i_psum_val = '0;
        bus.i_data_rdy = 1'b0;
        tick();
        tick();
        chk("rst_level", {28'd0, o_level}, 32'd0);
        chk("rst_val",   {31'd0, bus.o_data_val}, 32'd0);
        chk("rst_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("rst_cnt",   o_word_cnt, 32'd0);
        chk("rst_err",   err_psum_val, 32'd0);
        rst = 1'b1;

        // Streaming: each word visible one edge after capture
        bus.i_data_rdy = 1'b1;
        push(32'h04030201);
        chk("s_val_a",  {31'd0, bus.o_data_val}, 32'd1);
        chk("s_data_a", bus.o_data, 32'h04030201);
        push(32'h08070605);
        chk("s_data_b", bus.o_data, 32'h08070605);
        chk("s_lvl_b",  {28'd0, o_level}, 32'd1);
        push(32'h0C0B0A09);
        chk("s_data_c", bus.o_data, 32'h0C0B0A09);
        tick();
        chk("s_empty",  {31'd0, bus.o_data_val}, 32'd0);
        chk("s_cnt",    o_word_cnt, 32'd3);
        chk("s_err",    err_psum_val, 32'd0);

        // Backpressure fill and overflow
        i_clr = 1'b1;
        bus.i_data_rdy = 1'b0;
        tick();
        i_clr = 1'b0;
        chk("clr_cnt", o_word_cnt, 32'd0);
        for (int i = 1; i <= 5; i++) push(32'h10000000 + i);
        chk("f5_stall", {31'd0, bus.o_stall}, 32'd0);
        push(32'h10000006);
        chk("f6_stall", {31'd0, bus.o_stall}, 32'd1);
        chk("f6_level", {28'd0, o_level}, 32'd6);
        chk("f6_head",  bus.o_data, 32'h10000001);
        for (int i = 7; i <= 10; i++) push(32'h10000000 + i);
        chk("ovf_level", {28'd0, o_level}, 32'd8);
        chk("ovf_err",   err_psum_val, 32'h00020002);
        chk("ovf_cnt",   o_word_cnt, 32'd8);
        chk("ovf_head",  bus.o_data, 32'h10000001);

        // Full FIFO: simultaneous pop and push is not a drop
        bus.i_data_rdy = 1'b1;
        push(32'hDEADBEEF);
        chk("fp_level", {28'd0, o_level}, 32'd8);
        chk("fp_err",   err_psum_val, 32'h00020002);
        chk("fp_cnt",   o_word_cnt, 32'd9);
        for (int i = 2; i <= 8; i++) begin
            chk("drain", bus.o_data, 32'h10000000 + i);
            tick();
        end
        chk("drain_last", bus.o_data, 32'hDEADBEEF);
        tick();
        chk("drain_empty", {31'd0, bus.o_data_val}, 32'd0);

        // Partial valid, then clear with FIFO contents intact
        bus.i_data_rdy = 1'b0;
        push(32'hA1A2A3A4);
        push(32'hB1B2B3B4);
        bus.i_psum     = 32'hFFFFFFFF;
        bus.i_psum_val = 4'b0111;
        tick();
        bus.i_psum_val = 4'b0000;
        chk("part_err",   err_psum_val, 32'h00020003);
        chk("part_level", {28'd0, o_level}, 32'd2);
        chk("part_cnt",   o_word_cnt, 32'd11);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_err",   err_psum_val, 32'd0);
        chk("clr_cnt2",  o_word_cnt, 32'd0);
        chk("clr_level", {28'd0, o_level}, 32'd2);
        chk("clr_head",  bus.o_data, 32'hA1A2A3A4);

        // Asynchronous reset mid-cycle with words buffered
        push(32'hC1C2C3C4);
        push(32'hD1D2D3D4);
        chk("pre_rst_level", {28'd0, o_level}, 32'd4);
        #2 rst = 1'b0;
        #1;
        chk("arst_val",   {31'd0, bus.o_data_val}, 32'd0);
        chk("arst_level", {28'd0, o_level}, 32'd0);
        chk("arst_cnt",   o_word_cnt, 32'd0);
        tick();
        rst = 1'b1;
        push(32'h55667788);
        chk("post_rst_data",  bus.o_data, 32'h55667788);
        chk("post_rst_level", {28'd0, o_level}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
